// File: rtl/din_byte_packer.sv
// din_byte_packer
//   Packs a byte-serial stream into 8-lane groups (lanes a..h) and presents
//   each group to the dut din port with a vld/busy handshake. The assembly
//   register fills the next group while the output register holds the
//   current group through a dut stall.
//
//   Optional feature macro: DIN_PACKER_STATS_EN
//     When this macro is defined, the grp_cnt output is added. It is a
//     16-bit wrapping count of din transfers.

module din_byte_packer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_busy,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              din_vld,
    input  logic              din_busy,
    output logic [DATA_W-1:0] din_data_a,
    output logic [DATA_W-1:0] din_data_b,
    output logic [DATA_W-1:0] din_data_c,
    output logic [DATA_W-1:0] din_data_d,
    output logic [DATA_W-1:0] din_data_e,
    output logic [DATA_W-1:0] din_data_f,
    output logic [DATA_W-1:0] din_data_g,
    output logic [DATA_W-1:0] din_data_h
`ifdef DIN_PACKER_STATS_EN
    ,
    output logic [15:0]       grp_cnt
`endif
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] asm_q   [8];
    logic [DATA_W-1:0] asm_d   [8];
    logic [DATA_W-1:0] out_q   [8];
    logic [DATA_W-1:0] out_d   [8];
    logic [DATA_W-1:0] group_w [8];
    logic              din_vld_q, din_vld_d;

    logic accept_w;
    logic complete_w;
    logic out_free_w;

    assign out_free_w = !din_vld_q || !din_busy;
    assign accept_w   = (state_q == ST_FILL) && in_vld;
    assign complete_w = accept_w && ((idx_q == 3'd7) || in_last);

    // Group image after the incoming byte: the byte lands in lane idx, and an
    // early close zeroes every lane above it so no stale bytes survive.
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            if (3'(j) < idx_q) begin
                group_w[j] = asm_q[j];
            end else if (3'(j) == idx_q) begin
                group_w[j] = in_data;
            end else if (in_last) begin
                group_w[j] = '0;
            end else begin
                group_w[j] = asm_q[j];
            end
        end
    end

    // Next-state logic for assembly state, lane index, and both data registers.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement leaves a value unassigned and infers a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        out_d     = out_q;
        din_vld_d = din_vld_q && din_busy;

        case (state_q)
            ST_FILL: begin
                if (accept_w) begin
                    asm_d = group_w;
                    if (complete_w) begin
                        idx_d = 3'd0;
                        if (out_free_w) begin
                            out_d     = group_w;
                            din_vld_d = 1'b1;
                        end else begin
                            state_d = ST_FULL;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_FULL: begin
                if (out_free_w) begin
                    out_d     = asm_q;
                    din_vld_d = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State and data registers with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_FILL;
            idx_q     <= 3'd0;
            din_vld_q <= 1'b0;
            // NOTE: the lane arrays are reset too. They are eight small
            // registers, not a RAM, and the din data must read as zero
            // after reset.
            for (int j = 0; j < 8; j++) begin
                asm_q[j] <= '0;
                out_q[j] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that
            // every flop samples values from before the edge.
            state_q   <= state_d;
            idx_q     <= idx_d;
            din_vld_q <= din_vld_d;
            asm_q     <= asm_d;
            out_q     <= out_d;
        end
    end

    assign in_busy    = (state_q == ST_FULL);
    assign din_vld    = din_vld_q;
    assign din_data_a = out_q[0];
    assign din_data_b = out_q[1];
    assign din_data_c = out_q[2];
    assign din_data_d = out_q[3];
    assign din_data_e = out_q[4];
    assign din_data_f = out_q[5];
    assign din_data_g = out_q[6];
    assign din_data_h = out_q[7];

`ifdef DIN_PACKER_STATS_EN
    logic [15:0] grp_cnt_q, grp_cnt_d;

    // Count completed din transfers; the counter wraps naturally at 16 bits.
    always_comb begin
        grp_cnt_d = grp_cnt_q;
        if (din_vld_q && !din_busy) begin
            grp_cnt_d = grp_cnt_q + 16'd1;
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grp_cnt_q <= 16'd0;
        end else begin
            grp_cnt_q <= grp_cnt_d;
        end
    end

    assign grp_cnt = grp_cnt_q;
`endif

endmodule

// File: tb/tb_din_byte_packer.sv
// Self-checking bench for din_byte_packer: directed reset, basic, early-close
// and stall scenarios, then a randomized run against a group-level model.

module tb_din_byte_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic       in_busy;
    logic [7:0] in_data;
    logic       in_last;
    logic       din_vld;
    logic       din_busy;
    logic [7:0] din_data_a, din_data_b, din_data_c, din_data_d;
    logic [7:0] din_data_e, din_data_f, din_data_g, din_data_h;
`ifdef DIN_PACKER_STATS_EN
    logic [15:0] grp_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    din_byte_packer #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_busy    (in_busy),
        .in_data    (in_data),
        .in_last    (in_last),
        .din_vld    (din_vld),
        .din_busy   (din_busy),
        .din_data_a (din_data_a),
        .din_data_b (din_data_b),
        .din_data_c (din_data_c),
        .din_data_d (din_data_d),
        .din_data_e (din_data_e),
        .din_data_f (din_data_f),
        .din_data_g (din_data_g),
        .din_data_h (din_data_h)
`ifdef DIN_PACKER_STATS_EN
        ,
        .grp_cnt    (grp_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lanes();
        return {din_data_a, din_data_b, din_data_c, din_data_d,
                din_data_e, din_data_f, din_data_g, din_data_h};
    endfunction

    // Reference model: a group is the accepted bytes in order, lane a first,
    // zero-padded to eight lanes.
    function automatic logic [63:0] pack(input logic [7:0] b[8], input int n);
        logic [63:0] g = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < n) g[63-8*k -: 8] = b[k];
        end
        return g;
    endfunction

    logic [63:0] exp_q[$];

    task automatic do_reset();
        rst = 1'b0; in_vld = 1'b0; in_last = 1'b0; in_data = '0; din_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0]  acc[8];
        int          acc_n;
        int          sent;
        int          accepted;
        int          transfers;
        int          model_groups;
        logic        have_byte;
        logic [7:0]  cur_data;
        logic        cur_last;
        logic [63:0] g;

        rst = 1'b0; in_vld = 1'b0; in_last = 1'b0; in_data = '0; din_busy = 1'b0;
        @(negedge clk);
        do_reset();

        // T1: reset state, then reset in the middle of a group.
        check("t1_rst_vld", 64'(din_vld), 64'd0);
        check("t1_rst_data", lanes(), 64'd0);
        check("t1_rst_busy", 64'(in_busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1; in_data = 8'hE0 + 8'(i); in_last = 1'b0;
            @(negedge clk);
        end
        in_vld = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("t1_mid_vld", 64'(din_vld), 64'd0);
        check("t1_mid_data", lanes(), 64'd0);
        check("t1_mid_busy", 64'(in_busy), 64'd0);
        for (int i = 0; i < 8; i++) begin
            in_vld = 1'b1; in_data = 8'hA1 + 8'(i); in_last = 1'b0;
            @(negedge clk);
        end
        in_vld = 1'b0;
        check("t1_after_vld", 64'(din_vld), 64'd1);
        check("t1_after_data", lanes(), 64'hA1A2A3A4A5A6A7A8);
        @(negedge clk);

        // T2: eight consecutive bytes, no stall.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t2_vld_before", 64'(din_vld), 64'd0);
            in_vld = 1'b1; in_data = 8'(i + 1); in_last = 1'b0;
            @(negedge clk);
        end
        in_vld = 1'b0;
        check("t2_vld", 64'(din_vld), 64'd1);
        check("t2_data", lanes(), 64'h0102030405060708);
        @(negedge clk);
        check("t2_vld_drop", 64'(din_vld), 64'd0);

        // T3: early close, then a single-byte group.
        in_vld = 1'b1; in_last = 1'b0; in_data = 8'h11; @(negedge clk);
        in_data = 8'h22; @(negedge clk);
        in_data = 8'h33; in_last = 1'b1; @(negedge clk);
        in_vld = 1'b0; in_last = 1'b0;
        check("t3_vld", 64'(din_vld), 64'd1);
        check("t3_data", lanes(), 64'h1122330000000000);
        @(negedge clk);
        in_vld = 1'b1; in_data = 8'h44; in_last = 1'b1; @(negedge clk);
        in_vld = 1'b0; in_last = 1'b0;
        check("t3_single_data", lanes(), 64'h4400000000000000);
        @(negedge clk);

        // T4: output stall with two groups streamed.
        din_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("t4_busy_before", 64'(in_busy), 64'd0);
            in_vld = 1'b1; in_data = 8'(i + 1); in_last = 1'b0;
            @(negedge clk);
        end
        in_vld = 1'b0;
        check("t4_busy_full", 64'(in_busy), 64'd1);
        check("t4_g1_data", lanes(), 64'h0102030405060708);
        repeat (3) @(negedge clk);
        check("t4_g1_held", lanes(), 64'h0102030405060708);
        check("t4_vld_held", 64'(din_vld), 64'd1);
        din_busy = 1'b0; @(negedge clk);
        din_busy = 1'b1;
        check("t4_b2b_vld", 64'(din_vld), 64'd1);
        check("t4_g2_data", lanes(), 64'h090A0B0C0D0E0F10);
        check("t4_busy_free", 64'(in_busy), 64'd0);
        din_busy = 1'b0; @(negedge clk);
        check("t4_vld_drop", 64'(din_vld), 64'd0);

        // T5: random handshakes against the group-level model.
        acc_n = 0; sent = 0; accepted = 0; transfers = 0; model_groups = 0;
        have_byte = 1'b0; cur_data = '0; cur_last = 1'b0;
        for (int k = 0; k < 8; k++) acc[k] = '0;
        for (int cyc = 0; cyc < 20000 && (accepted < 1000 || exp_q.size() != 0); cyc++) begin
            if (!have_byte && sent < 1000 && ($urandom % 10) < 7) begin
                have_byte = 1'b1;
                cur_data  = 8'($urandom);
                cur_last  = (sent == 999) || (($urandom % 5) == 0);
                sent++;
            end
            in_vld   = have_byte;
            in_data  = cur_data;
            in_last  = cur_last;
            din_busy = (accepted < 1000) ? 1'($urandom % 2) : 1'b0;
            if (din_vld && !din_busy) begin
                transfers++;
                if (exp_q.size() == 0) begin
                    check("t5_underflow", 64'd1, 64'd0);
                end else begin
                    g = exp_q.pop_front();
                    check("t5_group", lanes(), g);
                end
            end
            if (in_vld && !in_busy) begin
                acc[acc_n] = cur_data;
                acc_n++;
                accepted++;
                if (acc_n == 8 || cur_last) begin
                    exp_q.push_back(pack(acc, acc_n));
                    model_groups++;
                    acc_n = 0;
                end
                have_byte = 1'b0;
            end
            @(negedge clk);
        end
        in_vld = 1'b0; in_last = 1'b0; din_busy = 1'b0;
        check("t5_bytes", 64'(accepted), 64'd1000);
        check("t5_left", 64'(exp_q.size()), 64'd0);
        check("t5_transfers", 64'(transfers), 64'(model_groups));
        @(negedge clk);

`ifdef DIN_PACKER_STATS_EN
        // T6: 65537 single-byte groups wrap the transfer counter to 1.
        do_reset();
        check("t6_cnt_rst", 64'(grp_cnt), 64'd0);
        for (int i = 0; i < 65537; i++) begin
            in_vld = 1'b1; in_data = 8'(i); in_last = 1'b1;
            @(negedge clk);
        end
        in_vld = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check("t6_cnt_wrap", 64'(grp_cnt), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
